// File: rtl/arp_resolver.sv
// arp_resolver: next-hop MAC resolution in front of arp_cache.
// Each lookup is classified as broadcast, on-subnet or via-gateway, then the
// cache is queried. On a miss, ARP requests are issued on a retry timer while
// cache writes are snooped for the reply. The result is either a MAC address
// or a timeout error. Every output is driven straight from a register.
module arp_resolver #(
  parameter int          REQUEST_COUNT  = 4,
  parameter logic [31:0] RETRY_INTERVAL = 32'd250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  output logic        cache_query_request_valid,
  input  logic        cache_query_request_ready,
  output logic [31:0] cache_query_request_ip,
  input  logic        cache_query_response_valid,
  output logic        cache_query_response_ready,
  input  logic        cache_query_response_error,
  input  logic [47:0] cache_query_response_mac,
  input  logic        cache_write_snoop_valid,
  input  logic [31:0] cache_write_snoop_ip,
  output logic        arp_tx_valid,
  input  logic        arp_tx_ready,
  output logic [31:0] arp_tx_target_ip,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask
);

  localparam int               CNT_W   = $clog2(REQUEST_COUNT + 1);
  localparam logic [CNT_W-1:0] REQ_MAX = CNT_W'(REQUEST_COUNT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_QUERY      = 3'd1,
    S_WAIT_RESP  = 3'd2,
    S_SEND_REQ   = 3'd3,
    S_WAIT_REPLY = 3'd4,
    S_RESPOND    = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [31:0]      target_r;
  logic [CNT_W-1:0] retry_cnt_r;
  logic [31:0]      timer_r;
  logic             snoop_flag_r;

  logic             arp_request_ready_r;
  logic             arp_response_valid_r;
  logic             arp_response_error_r;
  logic [47:0]      arp_response_mac_r;
  logic             cache_query_request_valid_r;
  logic             cache_query_response_ready_r;
  logic             arp_tx_valid_r;

  logic [31:0]      host_mask_s;
  logic             on_subnet_s;
  logic             is_bcast_s;
  logic             req_xfer_s;
  logic             qreq_xfer_s;
  logic             qresp_xfer_s;
  logic             tx_xfer_s;
  logic             resp_xfer_s;
  logic             snoop_state_s;
  logic             snoop_hit_s;
  logic             retry_left_s;
  logic             timer_zero_s;
  logic [47:0]      resp_mac_nx_s;
  logic             resp_err_nx_s;

  assign host_mask_s   = ~subnet_mask;
  assign on_subnet_s   = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
  // Limited broadcast, or the directed broadcast of our own subnet.
  assign is_bcast_s    = (arp_request_ip == 32'hFFFF_FFFF) ||
                         (((arp_request_ip & host_mask_s) == host_mask_s) && on_subnet_s);
  assign req_xfer_s    = arp_request_valid && arp_request_ready_r;
  assign qreq_xfer_s   = cache_query_request_valid_r && cache_query_request_ready;
  assign qresp_xfer_s  = cache_query_response_ready_r && cache_query_response_valid;
  assign tx_xfer_s     = arp_tx_valid_r && arp_tx_ready;
  assign resp_xfer_s   = arp_response_valid_r && arp_response_ready;
  assign snoop_state_s = (state_r == S_WAIT_RESP) || (state_r == S_SEND_REQ) ||
                         (state_r == S_WAIT_REPLY);
  assign snoop_hit_s   = snoop_state_s && cache_write_snoop_valid &&
                         (cache_write_snoop_ip == target_r);
  assign retry_left_s  = retry_cnt_r < REQ_MAX;
  assign timer_zero_s  = timer_r == 32'd0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state selection and the result to present when entering RESPOND.
  always_comb begin
    state_nx_s    = state_r;
    resp_mac_nx_s = arp_response_mac_r;
    resp_err_nx_s = arp_response_error_r;
    case (state_r)
      S_IDLE: begin
        if (req_xfer_s) begin
          if (is_bcast_s) begin
            state_nx_s    = S_RESPOND;
            resp_mac_nx_s = 48'hFFFF_FFFF_FFFF;
            resp_err_nx_s = 1'b0;
          end else begin
            state_nx_s = S_QUERY;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_QUERY: begin
        if (qreq_xfer_s) begin
          state_nx_s = S_WAIT_RESP;
        end else begin
          state_nx_s = S_QUERY;
        end
      end
      S_WAIT_RESP: begin
        if (!qresp_xfer_s) begin
          state_nx_s = S_WAIT_RESP;
        end else if (!cache_query_response_error) begin
          state_nx_s    = S_RESPOND;
          resp_mac_nx_s = cache_query_response_mac;
          resp_err_nx_s = 1'b0;
        end else if (snoop_flag_r) begin
          state_nx_s = S_QUERY;
        end else if (retry_left_s) begin
          state_nx_s = S_SEND_REQ;
        end else begin
          state_nx_s    = S_RESPOND;
          resp_mac_nx_s = 48'd0;
          resp_err_nx_s = 1'b1;
        end
      end
      S_SEND_REQ: begin
        if (tx_xfer_s) begin
          state_nx_s = S_WAIT_REPLY;
        end else begin
          state_nx_s = S_SEND_REQ;
        end
      end
      S_WAIT_REPLY: begin
        // A reply seen this cycle wins over the timer running out.
        if (snoop_flag_r || snoop_hit_s) begin
          state_nx_s = S_QUERY;
        end else if (!timer_zero_s) begin
          state_nx_s = S_WAIT_REPLY;
        end else if (retry_left_s) begin
          state_nx_s = S_SEND_REQ;
        end else begin
          state_nx_s    = S_RESPOND;
          resp_mac_nx_s = 48'd0;
          resp_err_nx_s = 1'b1;
        end
      end
      S_RESPOND: begin
        if (resp_xfer_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESPOND;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arp_request_ready_r          <= 1'b0;
      arp_response_valid_r         <= 1'b0;
      arp_response_error_r         <= 1'b0;
      arp_response_mac_r           <= 48'd0;
      cache_query_request_valid_r  <= 1'b0;
      cache_query_response_ready_r <= 1'b0;
      arp_tx_valid_r               <= 1'b0;
    end else begin
      arp_request_ready_r          <= (state_nx_s == S_IDLE);
      arp_response_valid_r         <= (state_nx_s == S_RESPOND);
      arp_response_error_r         <= resp_err_nx_s;
      arp_response_mac_r           <= resp_mac_nx_s;
      cache_query_request_valid_r  <= (state_nx_s == S_QUERY);
      cache_query_response_ready_r <= (state_nx_s == S_WAIT_RESP);
      arp_tx_valid_r               <= (state_nx_s == S_SEND_REQ);
    end
  end

  // Lookup target, retry counter, retry timer and reply snoop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_r     <= 32'd0;
      retry_cnt_r  <= '0;
      timer_r      <= 32'd0;
      snoop_flag_r <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && req_xfer_s && !is_bcast_s) begin
        target_r <= on_subnet_s ? arp_request_ip : gateway_ip;
      end
      if ((state_r == S_IDLE) && req_xfer_s) begin
        retry_cnt_r <= '0;
      end else if (tx_xfer_s) begin
        retry_cnt_r <= retry_cnt_r + 1'b1;
      end
      if (tx_xfer_s) begin
        timer_r <= RETRY_INTERVAL - 32'd1;
      end else if ((state_r == S_WAIT_REPLY) && !timer_zero_s) begin
        timer_r <= timer_r - 32'd1;
      end
      if (qreq_xfer_s) begin
        snoop_flag_r <= 1'b0;
      end else if (snoop_hit_s) begin
        snoop_flag_r <= 1'b1;
      end
    end
  end

  assign arp_request_ready          = arp_request_ready_r;
  assign arp_response_valid         = arp_response_valid_r;
  assign arp_response_error         = arp_response_error_r;
  assign arp_response_mac           = arp_response_mac_r;
  assign cache_query_request_valid  = cache_query_request_valid_r;
  assign cache_query_request_ip     = target_r;
  assign cache_query_response_ready = cache_query_response_ready_r;
  assign arp_tx_valid               = arp_tx_valid_r;
  assign arp_tx_target_ip           = target_r;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver with a small one-cycle-latency cache model.
module tb_arp_resolver;
  localparam int          RC = 3;
  localparam logic [31:0] RI = 32'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arp_request_valid = 1'b0;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip = 32'd0;
  logic        arp_response_valid;
  logic        arp_response_ready = 1'b0;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        cache_query_request_valid;
  logic        cache_query_request_ready = 1'b1;
  logic [31:0] cache_query_request_ip;
  logic        cache_query_response_valid = 1'b0;
  logic        cache_query_response_ready;
  logic        cache_query_response_error = 1'b0;
  logic [47:0] cache_query_response_mac = 48'd0;
  logic        cache_write_snoop_valid = 1'b0;
  logic [31:0] cache_write_snoop_ip = 32'd0;
  logic        arp_tx_valid;
  logic        arp_tx_ready = 1'b1;
  logic [31:0] arp_tx_target_ip;
  logic [31:0] local_ip    = 32'hC0A8_0180;
  logic [31:0] gateway_ip  = 32'hC0A8_0101;
  logic [31:0] subnet_mask = 32'hFFFF_FF00;

  always #5 clk = ~clk;

  arp_resolver #(.REQUEST_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
    .clk(clk), .rst(rst),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .cache_query_request_valid(cache_query_request_valid),
    .cache_query_request_ready(cache_query_request_ready),
    .cache_query_request_ip(cache_query_request_ip),
    .cache_query_response_valid(cache_query_response_valid),
    .cache_query_response_ready(cache_query_response_ready),
    .cache_query_response_error(cache_query_response_error),
    .cache_query_response_mac(cache_query_response_mac),
    .cache_write_snoop_valid(cache_write_snoop_valid),
    .cache_write_snoop_ip(cache_write_snoop_ip),
    .arp_tx_valid(arp_tx_valid), .arp_tx_ready(arp_tx_ready),
    .arp_tx_target_ip(arp_tx_target_ip),
    .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] tbl_ip  [8];
  logic [47:0] tbl_mac [8];
  int          tbl_n   = 0;
  int          q_cnt   = 0;
  int          tx_cnt  = 0;
  int          gap_n   = 0;
  int          low_run = 0;
  int          gaps    [8];
  logic [31:0] last_q_ip  = 32'd0;
  logic [31:0] last_tx_ip = 32'd0;
  logic [31:0] q_ip_pend  = 32'd0;
  logic        q_pend  = 1'b0;
  logic        r_pend  = 1'b0;
  logic        tx_prev = 1'b0;
  logic [47:0] rmac;
  logic        rerr;
  int          q0, t0;

  // Cache model and monitors. Runs on the falling edge: it acts on transfers
  // predicted at the previous falling edge and predicts those of the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      cache_query_response_valid = 1'b0;
      cache_query_response_error = 1'b0;
      cache_query_response_mac   = 48'd0;
      q_pend  = 1'b0;
      r_pend  = 1'b0;
      tx_prev = 1'b0;
    end else begin
      if (r_pend) cache_query_response_valid = 1'b0;
      if (q_pend) begin
        cache_query_response_valid = 1'b1;
        cache_query_response_error = 1'b1;
        cache_query_response_mac   = 48'd0;
        for (int i = 0; i < tbl_n; i++) begin
          if (tbl_ip[i] == q_ip_pend) begin
            cache_query_response_error = 1'b0;
            cache_query_response_mac   = tbl_mac[i];
          end
        end
      end
      q_pend = cache_query_request_valid && cache_query_request_ready;
      if (q_pend) begin
        q_cnt++;
        q_ip_pend = cache_query_request_ip;
        last_q_ip = cache_query_request_ip;
      end
      r_pend = cache_query_response_valid && cache_query_response_ready;
      if (arp_tx_valid && !tx_prev && gap_n < 8) begin
        gaps[gap_n] = low_run;
        gap_n++;
      end
      if (arp_tx_valid && arp_tx_ready) begin
        tx_cnt++;
        last_tx_ip = arp_tx_target_ip;
        low_run = 0;
      end else if (!arp_tx_valid) begin
        low_run++;
      end
      tx_prev = arp_tx_valid;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [127:0] outs_all();
    return {10'd0, arp_request_ready, arp_response_valid, arp_response_error,
            arp_response_mac, cache_query_request_valid, cache_query_request_ip,
            cache_query_response_ready, arp_tx_valid, arp_tx_target_ip};
  endfunction

  task automatic add_entry(input logic [31:0] ip, input logic [47:0] mac);
    tbl_ip[tbl_n]  = ip;
    tbl_mac[tbl_n] = mac;
    tbl_n++;
  endtask

  // Cache write of ip, seen by the resolver as a one-cycle snoop pulse.
  task automatic snoop(input logic [31:0] ip, input logic [47:0] mac);
    add_entry(ip, mac);
    cache_write_snoop_valid = 1'b1;
    cache_write_snoop_ip    = ip;
    step(1);
    cache_write_snoop_valid = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] ip);
    bit done = 1'b0;
    arp_request_valid = 1'b1;
    arp_request_ip    = ip;
    for (int i = 0; i < 20 && !done; i++) begin
      if (arp_request_ready) done = 1'b1;
      step(1);
    end
    arp_request_valid = 1'b0;
    chk("req_accept", 128'(done), 128'(1'b1));
    chk("ready_drop", 128'(arp_request_ready), 128'(1'b0));
  endtask

  task automatic wait_resp(input int budget, output logic [47:0] mac, output logic err);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (arp_response_valid) seen = 1'b1;
      else step(1);
    end
    chk("resp_seen", 128'(seen), 128'(1'b1));
    mac = arp_response_mac;
    err = arp_response_error;
    arp_response_ready = 1'b1;
    step(1);
    arp_response_ready = 1'b0;
    chk("resp_drop", 128'(arp_response_valid), 128'(1'b0));
  endtask

  task automatic wait_tx(input int target, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (tx_cnt >= target) seen = 1'b1;
      else step(1);
    end
    chk("tx_seen", 128'(seen), 128'(1'b1));
  endtask

  // Hard time limit in case the design wedges somewhere unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    add_entry(32'hC0A8_0164, 48'h0200_0000_0064);
    add_entry(32'hC0A8_0101, 48'h02AA_BBCC_DD01);

    // Reset state and first ready.
    step(3);
    chk("rst_outputs", outs_all(), 128'd0);
    rst = 1'b1;
    chk("ready_before_edge", 128'(arp_request_ready), 128'(1'b0));
    step(1);
    chk("ready_after_edge", 128'(arp_request_ready), 128'(1'b1));

    // Hit on the local subnet.
    q0 = q_cnt; t0 = tx_cnt;
    send_req(32'hC0A8_0164);
    wait_resp(20, rmac, rerr);
    chk("hit_mac", 128'(rmac), 128'(48'h0200_0000_0064));
    chk("hit_err", 128'(rerr), 128'(1'b0));
    chk("hit_qcnt", 128'(q_cnt - q0), 128'(1));
    chk("hit_qip", 128'(last_q_ip), 128'(32'hC0A8_0164));
    chk("hit_no_tx", 128'(tx_cnt - t0), 128'(0));
    chk("ready_back", 128'(arp_request_ready), 128'(1'b1));

    // Off-subnet resolves the gateway.
    q0 = q_cnt;
    send_req(32'h0808_0808);
    wait_resp(20, rmac, rerr);
    chk("gw_qip", 128'(last_q_ip), 128'(32'hC0A8_0101));
    chk("gw_mac", 128'(rmac), 128'(48'h02AA_BBCC_DD01));
    chk("gw_err", 128'(rerr), 128'(1'b0));
    chk("gw_qcnt", 128'(q_cnt - q0), 128'(1));

    // Limited and directed broadcast: answered one cycle after accept.
    q0 = q_cnt;
    send_req(32'hFFFF_FFFF);
    chk("bc1_lat", 128'(arp_response_valid), 128'(1'b1));
    wait_resp(5, rmac, rerr);
    chk("bc1_mac", 128'(rmac), 128'(48'hFFFF_FFFF_FFFF));
    chk("bc1_err", 128'(rerr), 128'(1'b0));
    send_req(32'hC0A8_01FF);
    chk("bc2_lat", 128'(arp_response_valid), 128'(1'b1));
    wait_resp(5, rmac, rerr);
    chk("bc2_mac", 128'(rmac), 128'(48'hFFFF_FFFF_FFFF));
    chk("bc2_err", 128'(rerr), 128'(1'b0));
    chk("bc_no_query", 128'(q_cnt - q0), 128'(0));

    // Miss, one ARP request, reply snooped 40 cycles after the transmit.
    q0 = q_cnt; t0 = tx_cnt;
    send_req(32'hC0A8_0105);
    wait_tx(t0 + 1, 20);
    chk("miss_tx_ip", 128'(last_tx_ip), 128'(32'hC0A8_0105));
    step(39);
    snoop(32'hC0A8_0105, 48'h0200_0000_0005);
    wait_resp(300, rmac, rerr);
    chk("miss_mac", 128'(rmac), 128'(48'h0200_0000_0005));
    chk("miss_err", 128'(rerr), 128'(1'b0));
    chk("miss_one_tx", 128'(tx_cnt - t0), 128'(1));
    chk("miss_requery", 128'(q_cnt - q0), 128'(2));

    // Timeout: three requests, each re-issued after RI idle cycles.
    q0 = q_cnt; t0 = tx_cnt;
    send_req(32'hC0A8_0107);
    wait_tx(t0 + 1, 20);
    gap_n = 0;
    step(30);
    snoop(32'hC0A8_0108, 48'h0200_0000_0008);
    wait_resp(600, rmac, rerr);
    chk("to_err", 128'(rerr), 128'(1'b1));
    chk("to_mac", 128'(rmac), 128'(48'd0));
    chk("to_tx_cnt", 128'(tx_cnt - t0), 128'(3));
    chk("to_qcnt", 128'(q_cnt - q0), 128'(1));
    chk("to_gap_n", 128'(gap_n), 128'(2));
    chk("to_gap0", 128'(gaps[0]), 128'(100));
    chk("to_gap1", 128'(gaps[1]), 128'(100));

    // Snoop in the very cycle the timer expires: re-query, no second transmit.
    q0 = q_cnt; t0 = tx_cnt;
    send_req(32'hC0A8_0109);
    wait_tx(t0 + 1, 20);
    step(99);
    snoop(32'hC0A8_0109, 48'h0200_0000_0009);
    wait_resp(50, rmac, rerr);
    chk("exp_mac", 128'(rmac), 128'(48'h0200_0000_0009));
    chk("exp_err", 128'(rerr), 128'(1'b0));
    chk("exp_one_tx", 128'(tx_cnt - t0), 128'(1));
    chk("exp_requery", 128'(q_cnt - q0), 128'(2));

    // Response held back for 10 cycles: valid and data must not move.
    send_req(32'hC0A8_0164);
    for (int i = 0; i < 20 && !arp_response_valid; i++) step(1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 128'(arp_response_valid), 128'(1'b1));
      chk("hold_mac", 128'(arp_response_mac), 128'(48'h0200_0000_0064));
      step(1);
    end
    wait_resp(5, rmac, rerr);
    chk("hold_final_mac", 128'(rmac), 128'(48'h0200_0000_0064));

    // Reset in the middle of WAIT_REPLY, then a fresh lookup.
    t0 = tx_cnt;
    send_req(32'hC0A8_010A);
    wait_tx(t0 + 1, 20);
    step(10);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", outs_all(), 128'd0);
    step(2);
    rst = 1'b1;
    step(5);
    chk("midrst_no_resp", 128'(arp_response_valid), 128'(1'b0));
    chk("midrst_no_tx", 128'(tx_cnt - t0), 128'(1));
    chk("midrst_ready", 128'(arp_request_ready), 128'(1'b1));
    send_req(32'hC0A8_0164);
    wait_resp(20, rmac, rerr);
    chk("post_rst_mac", 128'(rmac), 128'(48'h0200_0000_0064));
    chk("post_rst_err", 128'(rerr), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
